sram_arbiter: RTL

Two-port arbiter sharing the single SRAM controller between the data-side cache controller (port D) and the instruction fetch path (port I). Sits between the requesters and the SRAM controller's wr_en/rd_en/address/Write_Data/Read_Data/ready interface. It serialises accesses with round-robin fairness and returns each requester a one-cycle completion pulse with latched read data. Its completion signals also feed the pipeline freeze logic.

---
 rtl/sram_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the data port (D) and the
// instruction fetch port (I). Returns a one-cycle completion pulse and latched read data.
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_rd_req,
  input  logic               d_wr_req,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [WDATA_W-1:0] d_wdata,
  output logic [RDATA_W-1:0] d_rdata,
  output logic               d_ready,
  input  logic               i_rd_req,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [RDATA_W-1:0] i_rdata,
  output logic               i_ready,
  output logic               sram_rd_en,
  output logic               sram_wr_en,
  output logic [ADDR_W-1:0]  sram_address,
  output logic [WDATA_W-1:0] sram_wdata,
  input  logic [RDATA_W-1:0] sram_rdata,
  input  logic               sram_ready
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate masked requests
  // BUSY_D | port D access presented to SRAM, waiting for sram_ready
  // BUSY_I | port I read presented to SRAM, waiting for sram_ready
  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t state;
  logic   last_grant_i;
  logic   d_req_v;
  logic   i_req_v;
  logic   grant_d;
  logic   grant_i;

  // A port whose ready pulse is high this cycle is still holding its old request.
  assign d_req_v = (d_rd_req | d_wr_req) & ~d_ready;
  assign i_req_v = i_rd_req & ~i_ready;
  assign grant_d = d_req_v & (~i_req_v | last_grant_i);
  assign grant_i = i_req_v & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_i <= 1'b1;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
      d_rdata      <= '0;
      i_rdata      <= '0;
      d_ready      <= 1'b0;
      i_ready      <= 1'b0;
    end else begin
      d_ready <= 1'b0;
      i_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= BUSY_D;
            last_grant_i <= 1'b0;
            sram_wr_en   <= d_wr_req;
            sram_rd_en   <= ~d_wr_req;
            sram_address <= d_address;
            sram_wdata   <= d_wdata;
          end else if (grant_i) begin
            state        <= BUSY_I;
            last_grant_i <= 1'b1;
            sram_wr_en   <= 1'b0;
            sram_rd_en   <= 1'b1;
            sram_address <= i_address;
            sram_wdata   <= '0;
          end
        end
        BUSY_D: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_rd_en <= 1'b0;
            sram_wr_en <= 1'b0;
            d_ready    <= 1'b1;
            if (sram_rd_en) d_rdata <= sram_rdata;
          end
        end
        BUSY_I: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_rd_en <= 1'b0;
            sram_wr_en <= 1'b0;
            i_ready    <= 1'b1;
            i_rdata    <= sram_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
